mfgate_rr_arbiter: RTL
======================

Name: mfgate_rr_arbiter

Overview:
- Shares a single multifunction gate (mf_gate_core) between N requesters using a round-robin arbiter.
- Each requester presents operands x, y and a 2-bit function select {a,b} on a valid/ready handshake.
- The winner's operands pass through the core; the result is registered with the winner's index and offered downstream on a valid/ready interface.
- Sits between the bit-serial requesters and the shared logic resource, so no requester needs a private gate.

Parameters:
N, 4, number of requesters (2..16)
IDW, 2, width of requester index; must equal clog2(N)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
req_valid  input  N  request pending, one bit per requester
req_x  input  N  operand x per requester
req_y  input  N  operand y per requester
req_a  input  N  select bit a per requester
req_b  input  N  select bit b per requester
req_ready  output  N  one-hot grant; transfer occurs when req_valid[i] & req_ready[i]
out_valid  output  1  result register holds a result
out_f  output  1  gate result
out_id  output  IDW  index of the requester that produced out_f
out_ready  input  1  downstream accepts the result
grant_cnt  output  8  total accepted requests, wraps 255->0

Behaviour:
- Single clock; reset is synchronous and active-high: on rst at a rising clk edge, out_valid=0, out_f=0, out_id=0, rr_ptr=0, grant_cnt=0. req_ready is 0 while rst=1.
- Core function, with sel={a,b}: 00 -> x; 01 -> y; 10 -> y; 11 -> ~x. The core is purely combinational.
- can_accept = ~out_valid | out_ready. This is single-entry output buffering with same-cycle drain-and-refill.
- Arbitration is combinational. Scan indices rr_ptr, rr_ptr+1, ... mod N. The first i with req_valid[i]=1 wins.
- req_ready[i]=1 only for the winner, only when can_accept=1 and rst=0. At most one bit is ever set.
- On a transfer (winner exists and can_accept), at the next edge:
  - out_f <= core(x[i], y[i], a[i], b[i]).
  - out_id <= i.
  - out_valid <= 1.
  - rr_ptr <= (i+1) mod N.
  - grant_cnt <= grant_cnt+1.
- Latency is 1 cycle from grant to out_valid. Throughput is 1 result per cycle while out_ready=1.
- If out_valid & out_ready and there is no winner: out_valid <= 0, and out_f/out_id hold their values.
- If out_valid & ~out_ready: out_f, out_id and out_valid hold; all req_ready=0; rr_ptr holds.
- If there is no request: rr_ptr holds. The pointer moves only on a grant.
- Requester side: a requester must keep valid and its operands stable until granted. The block never drops an asserted request. Worst-case wait is N-1 grants.
- rr_ptr wraps N-1 -> 0. grant_cnt wraps 255 -> 0.
- Reset mid-operation: a pending output result is discarded and arbitration priority restarts at requester 0.
- Operand or select bits that are X on non-winning requesters must not affect outputs.

Decomposition:
- Shared package holds:
  - function-select constants: SEL_PASS_X=2'b00, SEL_Y_A=2'b01, SEL_Y_B=2'b10, SEL_NOT_X=2'b11;
  - a reference function mf_eval(x,y,sel) for benches.
- Natural sub-module: mf_gate_core, the combinational 4-input multifunction gate, instantiated once.
- Arbiter, pointer, output register and counter live in the top.

Test Plan:
- Reset: assert rst with req_valid=4'b1111 -> req_ready=0000, out_valid=0, grant_cnt=0. Release rst -> requester 0 granted first.
- Function check: only requester 2 valid, cycle through {a,b}=00,01,10,11 with x=1, y=0 -> out_f = 1,0,0,0 with out_id=2, each one cycle after its grant.
- Fairness: all 4 valid continuously, out_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles. out_id follows the same sequence one cycle later. grant_cnt=6 after six cycles.
- Backpressure: out_ready=0 for 3 cycles with results pending -> out_valid, out_f and out_id stable, req_ready=0000. When out_ready=1, drain and refill happen in the same cycle.
- Pointer skip: rr_ptr=1, only requester 0 valid -> requester 0 granted, rr_ptr becomes 1. Then requesters 0 and 3 valid -> requester 3 granted.
- Counter wrap: 256 grants -> grant_cnt returns to 0. A mid-stream rst clears out_valid and rr_ptr to 0.

Source files
------------

// File: rtl/mfgate_rr_arbiter_pkg.sv
// Shared definitions for the round-robin multifunction gate arbiter:
// function-select encodings and a reference evaluation function.
package mfgate_rr_arbiter_pkg;

  localparam logic [1:0] SEL_PASS_X = 2'b00;
  localparam logic [1:0] SEL_Y_A    = 2'b01;
  localparam logic [1:0] SEL_Y_B    = 2'b10;
  localparam logic [1:0] SEL_NOT_X  = 2'b11;

  function automatic logic mf_eval(input logic x, input logic y, input logic [1:0] sel);
    logic f;
    case (sel)
      SEL_PASS_X: f = x;
      SEL_Y_A:    f = y;
      SEL_Y_B:    f = y;
      SEL_NOT_X:  f = ~x;
      default:    f = x;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/mfgate_rr_arbiter_mf_gate_core.sv
// Combinational multifunction gate: sel picks x, y or ~x.
module mf_gate_core
  import mfgate_rr_arbiter_pkg::*;
(
  input  logic       x,
  input  logic       y,
  input  logic [1:0] sel,
  output logic       f
);

  always_comb begin
    f = x;
    case (sel)
      SEL_PASS_X:       f = x;
      SEL_Y_A, SEL_Y_B: f = y;
      SEL_NOT_X:        f = ~x;
      default:          f = x;
    endcase
  end

endmodule

// File: rtl/mfgate_rr_arbiter.sv
// Round-robin arbiter sharing one mf_gate_core among N requesters, with a
// single-entry registered output that can drain and refill in one cycle.
module mfgate_rr_arbiter
  import mfgate_rr_arbiter_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [N-1:0]   req_x,
  input  logic [N-1:0]   req_y,
  input  logic [N-1:0]   req_a,
  input  logic [N-1:0]   req_b,
  output logic [N-1:0]   req_ready,
  output logic           out_valid,
  output logic           out_f,
  output logic [IDW-1:0] out_id,
  input  logic           out_ready,
  output logic [7:0]     grant_cnt
);

  logic [IDW-1:0] rr_ptr_reg;
  logic           out_valid_reg;
  logic           out_f_reg;
  logic [IDW-1:0] out_id_reg;
  logic [7:0]     grant_cnt_reg;

  logic [IDW-1:0] scan_idx [N];
  logic [IDW-1:0] win_idx;
  logic           win_found;
  logic           can_accept;
  logic           xfer;
  logic           core_f;
  logic [IDW-1:0] rr_ptr_next;

  // scan_idx[k] is the requester examined k-th, starting at the pointer.
  for (genvar gi = 0; gi < N; gi++) begin : g_scan
    assign scan_idx[gi] = IDW'((32'(rr_ptr_reg) + gi) % N);
  end

  // Walk from the far end so the earliest position in the scan wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_valid[scan_idx[k]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[k];
      end
    end
  end

  assign can_accept  = ~out_valid_reg | out_ready;
  assign xfer        = win_found & can_accept & ~rst;
  assign rr_ptr_next = IDW'((32'(win_idx) + 1) % N);

  for (genvar gi = 0; gi < N; gi++) begin : g_grant
    assign req_ready[gi] = xfer && (win_idx == IDW'(gi));
  end

  // Only the winner's bits reach the core, so other requesters' operands are don't-care.
  mf_gate_core u_core (
    .x   (req_x[win_idx]),
    .y   (req_y[win_idx]),
    .sel ({req_a[win_idx], req_b[win_idx]}),
    .f   (core_f)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_f_reg     <= 1'b0;
      out_id_reg    <= '0;
      rr_ptr_reg    <= '0;
      grant_cnt_reg <= 8'd0;
    end else if (xfer) begin
      out_valid_reg <= 1'b1;
      out_f_reg     <= core_f;
      out_id_reg    <= win_idx;
      rr_ptr_reg    <= rr_ptr_next;
      grant_cnt_reg <= grant_cnt_reg + 8'd1;
    end else if (out_valid_reg && out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_f     = out_f_reg;
  assign out_id    = out_id_reg;
  assign grant_cnt = grant_cnt_reg;

endmodule
